jk_bank_sequencer: RTL
======================

Name: jk_bank_sequencer

Overview:
- Owns a bank of N JK-style storage bits and sequences J/K commands into them for two requesters.
- Each requester sends a command {op, idx, sweep} on a valid/ready handshake.
- A round-robin arbiter grants one command per cycle.
- A small FSM runs either a single-bit operation or a sweep that applies the op to every bit, one bit per cycle.
- Sits between control logic (test sequencers, T-flip-flop emulation, init logic) and the flip-flop bank it drives.

Parameters:
- N, 8, number of JK bits in the bank (1..64); IDX_W = max(1, clog2(N)) derived as localparam.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_op  in  2  00 hold, 01 clear (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1)
- req0_idx  in  IDX_W  target bit index (ignored when sweep=1)
- req0_sweep  in  1  1 = apply op to all bits 0..N-1
- req1_valid / req1_ready / req1_op / req1_idx / req1_sweep  same widths and meanings for requester 1
- q  out  N  bank contents
- busy  out  1  high while a sweep is in progress
- err  out  1  one-cycle pulse: accepted single op had idx >= N

Behaviour:
- Reset (async, immediate): q=0, state=IDLE, busy=0, err=0, ptr=0, last_grant=1 (requester 0 wins first contention), both readies 0.
- States:
  - IDLE: arbitrate.
  - SWEEP: walk ptr through 0..N-1.
- Handshake:
  - reqX_ready is combinational and is high only in IDLE for the granted requester.
  - Transfer occurs on the rising edge where valid && ready.
  - Valid must hold its command stable until accepted.
  - The command must not be withdrawn once valid is asserted.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester opposite last_grant.
  - last_grant updates only on transfer.
  - Exactly one grant per cycle; the loser's ready stays 0.
- Single op (sweep=0):
  - Applied at the transfer edge; q[idx] is updated at that edge and visible the next cycle.
  - Other bits hold.
  - State stays IDLE, so a new grant is possible the very next cycle.
- Out of range (idx >= N):
  - Accepted, no bit changes.
  - err=1 for the cycle after the transfer edge.
- Sweep (sweep=1):
  - At the transfer edge: state<=SWEEP, ptr<=0, op latched.
  - Each SWEEP edge applies the latched op to q[ptr] and increments ptr.
  - The edge applying ptr==N-1 returns to IDLE.
  - Bit k is updated at edge k+1 after transfer; the sweep occupies exactly N cycles.
  - busy=1 and both readies=0 throughout SWEEP.
  - N=1: single SWEEP cycle.
- Op semantics per bit:
  - hold keeps the value.
  - clear sets 0.
  - set sets 1.
  - toggle inverts.
  - hold still consumes a grant or sweep.
- Reset asserted mid-sweep aborts the sweep immediately; no partial state survives.

Optional Feature:
- JK_CMD_COUNT_EN:
  - Defined: adds output cmd_count[15:0], counting accepted commands (single, sweep or out-of-range; each counts 1). It wraps 0xFFFF->0 and is reset to 0.
  - Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package/include jk_pkg:
  - Op encodings OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TOG=2'b11.
  - FSM state encodings ST_IDLE, ST_SWEEP.
- Sub-module jk_cell:
  - Ports: clk, rst, en, op[1:0], q.
  - One bit with synchronous enable and async reset.
  - Instantiated N times via generate; the sequencer drives en/op per bit.

Test Plan:
- Reset then req0 single {set, idx=3} with N=8 → q=8'h08 the cycle after transfer; err=0; busy=0.
- req0 and req1 both valid, ops set idx1 / set idx2, held over consecutive cycles → req0 granted first, req1 next cycle; q=8'h06 after 2 cycles.
- q=8'h0F, req1 sweep toggle → busy high 8 cycles; q[k] flips at edge k+1; final q=8'hF0; readies 0 throughout.
- N=6, single set idx=7 → accepted, q unchanged, err pulses exactly one cycle.
- Reset asserted at sweep cycle 3 → q=0, busy=0, state IDLE immediately; a fresh request is accepted after reset deasserts.
- With JK_CMD_COUNT_EN: 3 singles + 1 sweep + 1 out-of-range → cmd_count=5.

Source files
------------

// File: rtl/jk_pkg.sv
// jk_pkg: op and FSM encodings shared by the JK bank sequencer and its cells
package jk_pkg;
    typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_CLR = 2'b01, OP_SET = 2'b10, OP_TOG = 2'b11} op_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;
    function automatic logic jk_next(input logic q, input op_t op);
        return op == OP_HOLD ? q : op == OP_CLR ? 1'b0 : op == OP_SET ? 1'b1 : !q;
    endfunction
endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK storage bit with synchronous enable and async reset
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  op_t  op,
    output logic q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else if (en) q <= jk_next(q, op);
endmodule

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: round-robin J/K command sequencer over an N-bit bank
// Defining JK_CMD_COUNT_EN adds cmd_count, a wrapping count of accepted commands.
module jk_bank_sequencer
    import jk_pkg::*;
#(
    parameter int N = 8,
    localparam int IDX_W = N > 1 ? $clog2(N) : 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [IDX_W-1:0] req0_idx,
    input  logic             req0_sweep,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [IDX_W-1:0] req1_idx,
    input  logic             req1_sweep,
    output logic [N-1:0]     q,
    output logic             busy,
    output logic             err
`ifdef JK_CMD_COUNT_EN
    ,output logic [15:0]     cmd_count
`endif
);
    state_t state, state_nx;
    op_t op_l, c_op;
    logic [IDX_W-1:0] ptr, c_idx;
    logic last_grant, g0, g1, xfer, c_sweep;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= state_nx;
    always_comb begin
        g0 = req0_valid && (!req1_valid || last_grant);
        g1 = req1_valid && !g0;
        c_op = op_t'(g1 ? req1_op : req0_op);
        c_idx = g1 ? req1_idx : req0_idx;
        c_sweep = g1 ? req1_sweep : req0_sweep;
        state_nx = state == ST_SWEEP ? (ptr == IDX_W'(N - 1) ? ST_IDLE : ST_SWEEP)
                                     : (xfer && c_sweep ? ST_SWEEP : ST_IDLE);
    end
    // readies forced low during reset so nothing looks accepted while the bank is cleared
    always_comb begin
        busy = state == ST_SWEEP;
        req0_ready = !rst && !busy && g0;
        req1_ready = !rst && !busy && g1;
        xfer = req0_ready || req1_ready;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr <= '0;
            op_l <= OP_HOLD;
            last_grant <= 1'b1;
            err <= 1'b0;
        end else begin
            err <= xfer && !c_sweep && ({1'b0, c_idx} >= (IDX_W + 1)'(N));
            if (xfer) last_grant <= g1;
            if (xfer && c_sweep) begin
                ptr <= '0;
                op_l <= c_op;
            end else if (busy) ptr <= ptr + 1'b1;
        end
`ifdef JK_CMD_COUNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) cmd_count <= '0;
        else if (xfer) cmd_count <= cmd_count + 16'd1;
`endif
    for (genvar i = 0; i < N; i++) begin : g_cell
        jk_cell u_cell (
            .clk(clk),
            .rst(rst),
            .en (busy ? ptr == IDX_W'(i) : xfer && !c_sweep && c_idx == IDX_W'(i)),
            .op (busy ? op_l : c_op),
            .q  (q[i])
        );
    end
endmodule
